// File: rtl/ov7670_sccb_cfg_seq.sv
// OV7670 power-up register loader: walks the config table and drives the SCCB byte master.
// Define SCCB_CFG_DELAY_EN to treat 16'hF0nn entries as nn-millisecond waits.
module ov7670_sccb_cfg_seq #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned DEPTH      = 77,
  parameter int unsigned LEN        = $clog2(DEPTH),
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 500
) (
  input  logic           sys_clk,
  input  logic           rstn,
  input  logic           i_start,
  output logic           o_bram_rden,
  output logic [LEN-1:0] o_bram_addr,
  input  logic [15:0]    i_bram_data,
  output logic           o_i2c_start,
  output logic           o_i2c_stop,
  output logic [7:0]     o_i2c_wr_byte,
  input  logic           i_i2c_tx_done,
  input  logic           i_i2c_ack,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic [LEN-1:0] o_index
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    DECODE,
    SEND_DEV,
    WAIT_DEV,
    SEND_REG,
    WAIT_REG,
    SEND_VAL,
    WAIT_VAL,
    STOP,
    GAP,
    DONE,
    ERR
`ifdef SCCB_CFG_DELAY_EN
    , DELAY
`endif
  } state_t;

  state_t        state, state_n;
  logic [LEN-1:0] index, index_n;
  logic [RW-1:0] retry, retry_n;
  logic          failed, failed_n;
  logic [7:0]    byte_n;
  logic [15:0]   word;
  logic [GW-1:0] gap_cnt;
  logic          gap_last;
  logic          nack;
  logic          adv;

  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign o_index  = index;

`ifdef SCCB_CFG_DELAY_EN
  localparam int unsigned MS = CLK_FREQ / 1000;
  localparam int PW = (MS > 1) ? $clog2(MS) : 1;

  logic [PW-1:0] pre;
  logic [7:0]    ms_left;
  logic          pre_wrap;
  logic          dly_last;

  assign pre_wrap = (pre == PW'(MS - 1));
  assign dly_last = pre_wrap && (ms_left == 8'd1);

  // ms_left tracks the latched word until DELAY starts counting it down
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      pre     <= '0;
      ms_left <= '0;
    end else if (state == DELAY) begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap)
        ms_left <= ms_left - 8'd1;
    end else begin
      pre     <= '0;
      ms_left <= word[7:0];
    end
  end
`endif

  always_comb begin
    state_n  = state;
    index_n  = index;
    retry_n  = retry;
    failed_n = failed;
    byte_n   = o_i2c_wr_byte;
    nack     = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_n  = FETCH;
          index_n  = '0;
          retry_n  = '0;
          failed_n = 1'b0;
        end
      end
      FETCH:     state_n = WAIT_DATA;
      WAIT_DATA: state_n = DECODE;
      DECODE: begin
        if (word == 16'hFFFF) begin
          state_n = DONE;
        end
`ifdef SCCB_CFG_DELAY_EN
        else if (word[15:8] == 8'hF0) begin
          if (word[7:0] == 8'h00)
            adv = 1'b1;
          else
            state_n = DELAY;
        end
`endif
        else begin
          state_n = SEND_DEV;
          byte_n  = DEV_ADDR;
        end
      end
      SEND_DEV: state_n = WAIT_DEV;
      WAIT_DEV: begin
        if (i_i2c_tx_done) begin
          if (i_i2c_ack) begin
            nack = 1'b1;
          end else begin
            state_n = SEND_REG;
            byte_n  = word[15:8];
          end
        end
      end
      SEND_REG: state_n = WAIT_REG;
      WAIT_REG: begin
        if (i_i2c_tx_done) begin
          if (i_i2c_ack) begin
            nack = 1'b1;
          end else begin
            state_n = SEND_VAL;
            byte_n  = word[7:0];
          end
        end
      end
      SEND_VAL: state_n = WAIT_VAL;
      WAIT_VAL: begin
        if (i_i2c_tx_done) begin
          if (i_i2c_ack)
            nack = 1'b1;
          else
            state_n = STOP;
        end
      end
      STOP: state_n = GAP;
      GAP: begin
        if (gap_last) begin
          if (!failed) begin
            adv = 1'b1;
          end else if (retry < RW'(MAX_RETRY)) begin
            state_n  = FETCH;
            failed_n = 1'b0;
          end else begin
            state_n = ERR;
          end
        end
      end
`ifdef SCCB_CFG_DELAY_EN
      DELAY: begin
        if (dly_last)
          adv = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase

    if (nack) begin
      state_n  = STOP;
      retry_n  = retry + RW'(1);
      failed_n = 1'b1;
    end

    // shared by a clean GAP and a finished delay entry
    if (adv) begin
      retry_n = '0;
      if (index == LEN'(DEPTH - 1)) begin
        state_n = DONE;
      end else begin
        state_n = FETCH;
        index_n = index + LEN'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state         <= IDLE;
      index         <= '0;
      retry         <= '0;
      failed        <= 1'b0;
      word          <= '0;
      gap_cnt       <= '0;
      o_bram_rden   <= 1'b0;
      o_bram_addr   <= '0;
      o_i2c_start   <= 1'b0;
      o_i2c_stop    <= 1'b0;
      o_i2c_wr_byte <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state         <= state_n;
      index         <= index_n;
      retry         <= retry_n;
      failed        <= failed_n;
      o_i2c_wr_byte <= byte_n;
      if (state == WAIT_DATA)
        word <= i_bram_data;
      gap_cnt       <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      o_bram_rden   <= (state_n == FETCH);
      o_bram_addr   <= index_n;
      o_i2c_start   <= (state_n == SEND_DEV) ||
                       (state_n == SEND_REG) ||
                       (state_n == SEND_VAL);
      o_i2c_stop    <= (state_n == STOP);
      o_busy        <= (state_n != IDLE) &&
                       (state_n != DONE) &&
                       (state_n != ERR);
      o_done        <= (state_n == DONE);
      o_err         <= (state_n == ERR);
    end
  end

endmodule
